// File: rtl/ysyx_25030093_ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ysyx_25030093_ifu_pkg;

   localparam int unsigned IFU_ADDR_W       = 32;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

   localparam logic [1:0] FAULT_NONE     = 2'b00;
   localparam logic [1:0] FAULT_MISALIGN = 2'b01;
   localparam logic [1:0] FAULT_BUSERR   = 2'b10;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   typedef enum logic [2:0] {
      S_LAUNCH = 3'd0,
      S_REQ    = 3'd1,
      S_WAIT_R = 3'd2,
      S_HOLD   = 3'd3,
      S_IDLE   = 3'd4
   } ifu_state_e;

endpackage

// File: rtl/ysyx_25030093_ifu.sv
// Instruction fetch unit: one AXI4-Lite read per retired instruction, result
// presented to the IDU through a valid/ready handshake.
module ysyx_25030093_ifu
   import ysyx_25030093_ifu_pkg::*;
#(
   parameter int unsigned ADDR_W   = IFU_ADDR_W,
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc,
   input  logic              wbu_done,
   output logic [ADDR_W-1:0] araddr,
   output logic              arvalid,
   input  logic              arready,
   input  logic [31:0]       rdata,
   input  logic [1:0]        rresp,
   input  logic              rvalid,
   output logic              rready,
   output logic [31:0]       inst,
   output logic [ADDR_W-1:0] inst_pc,
   output logic [1:0]        fault,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       fetch_count
);

   ifu_state_e state;

   // Single registered FSM; every output is a flop updated here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_LAUNCH;
         arvalid     <= 1'b0;
         rready      <= 1'b0;
         out_valid   <= 1'b0;
         inst        <= 32'h0;
         inst_pc     <= ADDR_W'(RESET_PC);
         fault       <= FAULT_NONE;
         araddr      <= '0;
         fetch_count <= 32'h0;
      end else begin
         case (state)
            S_LAUNCH: begin
               araddr  <= pc;
               inst_pc <= pc;
               // A misaligned PC never reaches the bus; report it directly.
               if (pc[1:0] != 2'b00) begin
                  inst      <= 32'h0;
                  fault     <= FAULT_MISALIGN;
                  out_valid <= 1'b1;
                  state     <= S_HOLD;
               end else begin
                  arvalid <= 1'b1;
                  state   <= S_REQ;
               end
            end
            S_REQ: begin
               if (arready) begin
                  arvalid <= 1'b0;
                  rready  <= 1'b1;
                  state   <= S_WAIT_R;
               end
            end
            S_WAIT_R: begin
               if (rvalid) begin
                  inst      <= rdata;
                  fault     <= (rresp == RESP_OKAY) ? FAULT_NONE : FAULT_BUSERR;
                  rready    <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= S_HOLD;
               end
            end
            S_HOLD: begin
               // A retire coinciding with the accept starts the next fetch at once.
               if (out_ready) begin
                  out_valid   <= 1'b0;
                  fetch_count <= fetch_count + 32'd1;
                  state       <= wbu_done ? S_LAUNCH : S_IDLE;
               end
            end
            S_IDLE: begin
               if (wbu_done) state <= S_LAUNCH;
            end
            default: state <= S_LAUNCH;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_25030093_ifu.sv
// Scoreboard bench for the fetch unit with a small AXI4-Lite read slave model.
module tb_ysyx_25030093_ifu;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [1:0]  fault;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc;
   logic        wbu_done;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic [1:0]  fault;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] fetch_count;

   int total = 0;
   int bad   = 0;

   logic [31:0] ar_q[$];
   exp_t        out_q[$];
   int          exp_cnt = 0;
   int          ar_hi   = 0;

   int          ar_delay  = 0;
   int          r_delay   = 0;
   logic [31:0] cfg_rdata = 32'h0;
   logic [1:0]  cfg_rresp = 2'b00;

   ysyx_25030093_ifu dut (
      .clk(clk), .rst(rst), .pc(pc), .wbu_done(wbu_done),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .inst(inst), .inst_pc(inst_pc), .fault(fault),
      .out_valid(out_valid), .out_ready(out_ready), .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // AXI read slave: programmable AR and R delays, abandons everything on rst.
   initial begin
      int ar_cnt;
      int r_cnt;
      arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
      ar_cnt = 0; r_cnt = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            arready = 1'b0; rvalid = 1'b0; ar_cnt = 0; r_cnt = 0;
         end else begin
            if (arvalid === 1'b1 && !arready) begin
               if (ar_cnt == ar_delay) arready = 1'b1;
               else ar_cnt++;
            end else begin
               arready = 1'b0; ar_cnt = 0;
            end
            if (rready === 1'b1 && !rvalid) begin
               if (r_cnt == r_delay) begin
                  rvalid = 1'b1; rdata = cfg_rdata; rresp = cfg_rresp;
               end else r_cnt++;
            end else if (rready !== 1'b1) begin
               rvalid = 1'b0; r_cnt = 0;
            end
         end
      end
   end

   // Monitor: samples what the DUT will see at the coming rising edge.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (rst) begin
            exp_cnt = 0;
         end else begin
            chk("ar_r_exclusive", 32'(arvalid && rready), 32'd0);
            if (arvalid) begin
               ar_hi++;
               if (ar_q.size() == 0) chk("unexpected_ar", araddr, 32'hFFFF_FFFF);
               else begin
                  chk("araddr", araddr, ar_q[0]);
                  if (arready) void'(ar_q.pop_front());
               end
            end
            if (out_valid && out_ready) begin
               if (out_q.size() == 0) chk("unexpected_out", inst_pc, 32'hFFFF_FFFF);
               else begin
                  exp_t e;
                  e = out_q.pop_front();
                  chk("inst", inst, e.inst);
                  chk("inst_pc", inst_pc, e.pc);
                  chk("fault", 32'(fault), 32'(e.fault));
                  chk("count_before_accept", fetch_count, 32'(exp_cnt));
                  exp_cnt++;
               end
            end
         end
      end
   end

   task automatic retire(input logic [31:0] new_pc);
      @(negedge clk); wbu_done = 1'b1;
      @(negedge clk); wbu_done = 1'b0; pc = new_pc;
   endtask

   task automatic expect_fetch(input logic [31:0] a, input logic [31:0] d,
                               input logic [1:0] resp, input bit push_out);
      exp_t e;
      cfg_rdata = d; cfg_rresp = resp;
      if (a[1:0] != 2'b00) begin
         e = '{inst: 32'h0, pc: a, fault: 2'b01};
      end else begin
         ar_q.push_back(a);
         e = '{inst: d, pc: a, fault: (resp == 2'b00) ? 2'b00 : 2'b10};
      end
      if (push_out) out_q.push_back(e);
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((ar_q.size() != 0 || out_q.size() != 0) && n < 80) begin
         @(negedge clk); n++;
      end
      if (n >= 80) chk("drain_timeout", 32'(out_q.size() + ar_q.size()), 32'd0);
      @(negedge clk);
   endtask

   task automatic wait_out_valid();
      int n = 0;
      while (out_valid !== 1'b1 && n < 40) begin
         @(negedge clk); n++;
      end
      if (n >= 40) chk("out_valid_timeout", 32'(out_valid), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: sim time exceeded, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; pc = 32'h8000_0000; wbu_done = 1'b0; out_ready = 1'b1;

      // Reset state
      expect_fetch(32'h8000_0000, 32'h0000_0413, 2'b00, 1'b1);
      repeat (3) @(negedge clk);
      chk("rst_arvalid", 32'(arvalid), 32'd0);
      chk("rst_rready", 32'(rready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_inst", inst, 32'h0);
      chk("rst_inst_pc", inst_pc, 32'h8000_0000);
      chk("rst_fault", 32'(fault), 32'd0);
      chk("rst_araddr", araddr, 32'h0);
      chk("rst_fetch_count", fetch_count, 32'h0);
      rst = 1'b0;
      wait_drain();
      chk("count_t1", fetch_count, 32'd1);

      // AR stalled 5 cycles
      ar_delay = 5; ar_hi = 0;
      expect_fetch(32'h8000_0004, 32'h0010_0093, 2'b00, 1'b1);
      retire(32'h8000_0004);
      wait_drain();
      chk("ar_valid_cycles", 32'(ar_hi), 32'd6);
      ar_delay = 0;

      // Bus error
      expect_fetch(32'h8000_0008, 32'hDEAD_BEEF, 2'b10, 1'b1);
      retire(32'h8000_0008);
      wait_drain();

      // Misaligned PC: no bus traffic, result next cycle
      ar_hi = 0;
      expect_fetch(32'h8000_0006, 32'h1234_5678, 2'b00, 1'b1);
      out_ready = 1'b0;
      retire(32'h8000_0006);
      @(negedge clk);
      chk("mis_out_valid", 32'(out_valid), 32'd1);
      chk("mis_fault", 32'(fault), 32'd1);
      out_ready = 1'b1;
      wait_drain();
      chk("mis_no_ar", 32'(ar_hi), 32'd0);
      chk("count_t4", fetch_count, 32'd4);

      // IDU stall with a stray wbu_done in HOLD
      out_ready = 1'b0; ar_hi = 0;
      expect_fetch(32'h8000_000C, 32'h00A0_0513, 2'b00, 1'b1);
      retire(32'h8000_000C);
      wait_out_valid();
      ar_hi = 0;
      for (int i = 0; i < 4; i++) begin
         chk("hold_valid", 32'(out_valid), 32'd1);
         chk("hold_inst", inst, 32'h00A0_0513);
         chk("hold_pc", inst_pc, 32'h8000_000C);
         chk("hold_fault", 32'(fault), 32'd0);
         if (i == 1) wbu_done = 1'b1;
         if (i == 2) wbu_done = 1'b0;
         @(negedge clk);
      end
      out_ready = 1'b1;
      wait_drain();
      repeat (4) @(negedge clk);
      chk("hold_no_ar", 32'(ar_hi), 32'd0);
      chk("count_t5", fetch_count, 32'd5);

      // Retire coinciding with the accept launches immediately
      out_ready = 1'b0;
      expect_fetch(32'h8000_0010, 32'h0000_0013, 2'b00, 1'b1);
      retire(32'h8000_0010);
      wait_out_valid();
      expect_fetch(32'h8000_0014, 32'h0050_0593, 2'b00, 1'b1);
      out_ready = 1'b1; wbu_done = 1'b1;
      @(negedge clk); wbu_done = 1'b0; pc = 32'h8000_0014;
      wait_drain();
      chk("count_t6", fetch_count, 32'd7);

      // Reset while waiting for read data
      r_delay = 20;
      expect_fetch(32'h8000_0018, 32'hBAD0_BAD0, 2'b00, 1'b0);
      retire(32'h8000_0018);
      begin
         int n = 0;
         while (rready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
         chk("reach_wait_r", 32'(rready), 32'd1);
      end
      rst = 1'b1; pc = 32'h8000_0000; r_delay = 0;
      @(negedge clk);
      chk("rst_wr_rready", 32'(rready), 32'd0);
      chk("rst_wr_out_valid", 32'(out_valid), 32'd0);
      chk("rst_wr_arvalid", 32'(arvalid), 32'd0);
      chk("rst_wr_count", fetch_count, 32'd0);
      expect_fetch(32'h8000_0000, 32'h0000_0297, 2'b00, 1'b1);
      rst = 1'b0;
      @(negedge clk);
      chk("launch_after_rst", 32'(arvalid), 32'd1);
      wait_drain();
      chk("count_t7", fetch_count, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
